// File: rtl/pll_phase_step_ctrl_m_if.sv
// pll_phase_step_ctrl_m_if: MMCM dynamic phase-shift port (psen/psincdec/psdone)
interface pll_phase_step_ctrl_m_if;
   logic ps_en;
   logic ps_incdec;
   logic ps_done;
   modport master (output ps_en, output ps_incdec, input ps_done);
   modport slave  (input ps_en, input ps_incdec, output ps_done);
endinterface

// File: rtl/pll_phase_step_ctrl_m.sv
// pll_phase_step_ctrl_m: queues +/-1 phase step requests and issues them one at a time to the MMCM
module pll_phase_step_ctrl_m #(
   parameter int PEND_WIDTH  = 8,
   parameter int PHASE_WIDTH = 16,
   parameter int TIMEOUT     = 1023,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_ph_inc,
   input  logic                          i_ph_dec,
   input  logic                          i_locked,
   input  logic                          i_clr,
   pll_phase_step_ctrl_m_if.master       ps,
   output logic                          o_busy,
   output logic signed [PEND_WIDTH-1:0]  o_pending,
   output logic signed [PHASE_WIDTH-1:0] o_phase,
   output logic                          o_err_timeout,
   output logic                          o_err_ovf
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] GAP   = 2'd3;
   localparam int PW1 = PEND_WIDTH + 1;
   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int GW  = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
   localparam logic signed [PW1-1:0] MAXP = PW1'(2 ** (PEND_WIDTH - 1) - 1);
   localparam logic signed [PW1-1:0] MINP = -MAXP;
   localparam logic [GW-1:0] GAP_LD = GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

   logic [1:0]                   r_state;
   logic                         r_ps_en;
   logic                         r_dir;
   logic signed [PEND_WIDTH-1:0] r_pend;
   logic signed [PHASE_WIDTH-1:0] r_phase;
   logic                         r_err_to;
   logic                         r_err_ovf;
   logic [TW-1:0]                r_to_cnt;
   logic [GW-1:0]                r_gap_cnt;
   logic                         w_done;
   logic                         w_tmo;
   logic                         w_hi;
   logic                         w_lo;
   logic signed [PW1-1:0]        w_cons;
   logic signed [PW1-1:0]        w_sum;

   // one extra bit of headroom so the clamp sees the true sum
   always_comb begin
      w_done = r_state == WAIT && ps.ps_done;
      w_tmo  = r_state == WAIT && !ps.ps_done && r_to_cnt == '0;
      w_cons = !w_done ? '0 : r_dir ? PW1'(1) : '1;
      w_sum  = PW1'(r_pend) + PW1'(i_ph_inc) - PW1'(i_ph_dec) - w_cons;
      w_hi   = w_sum > MAXP;
      w_lo   = w_sum < MINP;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ps_en   <= 1'b0;
         r_dir     <= 1'b0;
         r_pend    <= '0;
         r_phase   <= '0;
         r_err_to  <= 1'b0;
         r_err_ovf <= 1'b0;
         r_to_cnt  <= '0;
         r_gap_cnt <= '0;
      end else begin
         r_ps_en   <= 1'b0;
         r_pend    <= w_tmo ? '0 : w_hi ? MAXP[PEND_WIDTH-1:0] : w_lo ? MINP[PEND_WIDTH-1:0] : w_sum[PEND_WIDTH-1:0];
         r_phase   <= i_clr ? '0 : !w_done ? r_phase : r_dir ? r_phase + PHASE_WIDTH'(1) : r_phase - PHASE_WIDTH'(1);
         r_err_to  <= !i_clr && (r_err_to || w_tmo);
         r_err_ovf <= !i_clr && (r_err_ovf || ((w_hi || w_lo) && !w_tmo));
         case (r_state)
            IDLE: if (r_pend != '0 && i_locked) begin
               r_dir   <= !r_pend[PEND_WIDTH-1];
               r_ps_en <= 1'b1;
               r_state <= ISSUE;
            end
            ISSUE: begin
               r_to_cnt <= TW'(TIMEOUT);
               r_state  <= WAIT;
            end
            WAIT: if (w_done) begin
               r_gap_cnt <= GAP_LD;
               r_state   <= GAP_CYCLES == 0 ? IDLE : GAP;
            end else if (w_tmo) begin
               r_state <= IDLE;
            end else begin
               r_to_cnt <= r_to_cnt - TW'(1);
            end
            default: if (r_gap_cnt == '0) r_state <= IDLE;
                     else r_gap_cnt <= r_gap_cnt - GW'(1);
         endcase
      end
   end

   assign ps.ps_en      = r_ps_en;
   assign ps.ps_incdec  = r_dir;
   assign o_busy        = r_state != IDLE;
   assign o_pending     = r_pend;
   assign o_phase       = r_phase;
   assign o_err_timeout = r_err_to;
   assign o_err_ovf     = r_err_ovf;
endmodule

// File: tb/tb_pll_phase_step_ctrl_m.sv
// tb_pll_phase_step_ctrl_m: directed and randomized checks against a timestamp-based reference model
module tb_pll_phase_step_ctrl_m;
   localparam int PW   = 8;
   localparam int PHW  = 16;
   localparam int T    = 16;
   localparam int G    = 4;
   localparam int PMAX = 127;

   logic clk = 1'b0, rst = 1'b1, ph_inc = 1'b0, ph_dec = 1'b0, locked = 1'b0, clr = 1'b0;
   logic busy, err_to, err_ovf;
   logic signed [PW-1:0]  pending;
   logic signed [PHW-1:0] phase;

   pll_phase_step_ctrl_m_if pll();

   pll_phase_step_ctrl_m #(.PEND_WIDTH(PW), .PHASE_WIDTH(PHW), .TIMEOUT(T), .GAP_CYCLES(G)) u_dut (
      .clk(clk), .rst(rst), .i_ph_inc(ph_inc), .i_ph_dec(ph_dec), .i_locked(locked), .i_clr(clr),
      .ps(pll), .o_busy(busy), .o_pending(pending), .o_phase(phase),
      .o_err_timeout(err_to), .o_err_ovf(err_ovf));

   always #5 clk = ~clk;

   int n_chk = 0, n_fail = 0, cyc = 0;
   int m_pend = 0, m_phase = 0, m_dir = 0, t_issue = -10, t_free = 0;
   bit m_step = 0, m_incdec = 0, m_ovf = 0, m_to = 0;
   int dcnt = 0, lat = 5, n_en_inc = 0, n_en_dec = 0;
   bit rsp_on = 1, rnd_lat = 0;
   int en_q[$];

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic int wrap_ph(input int v);
      logic signed [PHW-1:0] t;
      t = PHW'(v);
      return int'(t);
   endfunction

   // A step is outstanding from its ps_en cycle (t_issue) until done/timeout; the block is idle from t_free on.
   task automatic model_edge();
      int np;
      bit disc, idle;
      if (rst) begin
         m_pend = 0; m_phase = 0; m_ovf = 0; m_to = 0; m_step = 0; m_incdec = 0;
         t_free = 0; t_issue = -10;
         return;
      end
      idle = !m_step && cyc >= t_free;
      np   = m_pend + int'(ph_inc) - int'(ph_dec);
      disc = 0;
      if (m_step && cyc > t_issue) begin
         if (pll.ps_done) begin
            np -= m_dir; m_phase += m_dir; m_step = 0; t_free = cyc + 1 + G;
         end else if (cyc == t_issue + 1 + T) begin
            m_to = 1; np = 0; disc = 1; m_step = 0; t_free = cyc + 1;
         end
      end
      if (idle && m_pend != 0 && locked) begin
         m_step = 1; t_issue = cyc + 1; m_dir = m_pend > 0 ? 1 : -1; m_incdec = m_pend > 0;
      end
      if (!disc && np > PMAX) begin np = PMAX; m_ovf = 1; end
      if (!disc && np < -PMAX) begin np = -PMAX; m_ovf = 1; end
      if (clr) begin m_phase = 0; m_ovf = 0; m_to = 0; end
      m_pend = np;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
      chk("ps_en", pll.ps_en, m_step && t_issue == cyc);
      chk("ps_incdec", pll.ps_incdec, m_incdec);
      chk("busy", busy, m_step || cyc < t_free);
      chk("pending", pending, m_pend);
      chk("phase", phase, wrap_ph(m_phase));
      chk("err_timeout", err_to, m_to);
      chk("err_ovf", err_ovf, m_ovf);
      if (pll.ps_en) begin
         en_q.push_back(cyc);
         if (pll.ps_incdec) n_en_inc++; else n_en_dec++;
      end
      if (rsp_on) begin
         pll.ps_done = 1'b0;
         if (pll.ps_en) dcnt = rnd_lat ? int'($urandom_range(20, 1)) : lat;
         else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0) pll.ps_done = 1'b1;
         end else if (rnd_lat && $urandom_range(49, 0) == 0) pll.ps_done = 1'b1;
      end
   endtask

   task automatic wait_idle(input string tag, input int max);
      bit ok;
      ok = 0;
      for (int i = 0; i < max && !ok; i++) begin
         if (!busy && pending == 0) ok = 1;
         else step();
      end
      if (!busy && pending == 0) ok = 1;
      chk(tag, ok, 1);
   endtask

   task automatic wait_en(input string tag, input int max);
      bit ok;
      ok = pll.ps_en;
      for (int i = 0; i < max && !ok; i++) begin
         step();
         ok = pll.ps_en;
      end
      chk(tag, ok, 1);
   endtask

   int t0;

   initial begin
      pll.ps_done = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_busy", busy, 0);
      chk("rst_pending", pending, 0);
      // three spaced increments, PLL answers 5 cycles after each ps_en
      locked = 1'b1; en_q.delete(); n_en_inc = 0;
      for (int k = 0; k < 3; k++) begin
         ph_inc = 1'b1; step(); ph_inc = 1'b0; step();
      end
      wait_idle("t1_idle", 200);
      chk("t1_pulses", en_q.size(), 3);
      chk("t1_incdec", n_en_inc, 3);
      for (int k = 1; k < en_q.size(); k++) chk("t1_spacing", int'(en_q[k] - en_q[k-1] >= 3 + G), 1);
      chk("t1_phase", phase, 3);
      chk("t1_pending", pending, 0);
      // simultaneous inc and dec cancel
      en_q.delete();
      ph_inc = 1'b1; ph_dec = 1'b1; step(); ph_inc = 1'b0; ph_dec = 1'b0;
      repeat (10) step();
      chk("t2_pending", pending, 0);
      chk("t2_pulses", en_q.size(), 0);
      // direction reverses while a +1 step is in flight
      clr = 1'b1; step(); clr = 1'b0;
      en_q.delete(); n_en_dec = 0;
      ph_inc = 1'b1; step(); ph_inc = 1'b0;
      wait_en("t3_en", 20);
      step();
      ph_dec = 1'b1; repeat (2) step(); ph_dec = 1'b0;
      repeat (3) step();
      chk("t3_phase_mid", phase, 1);
      chk("t3_pending_mid", pending, -2);
      wait_idle("t3_idle", 200);
      chk("t3_phase_end", phase, -1);
      chk("t3_dec_pulses", n_en_dec, 2);
      chk("t3_pulses", en_q.size(), 3);
      // timeout: no ps_done at all
      rsp_on = 0; pll.ps_done = 1'b0;
      ph_inc = 1'b1; step(); ph_inc = 1'b0;
      wait_en("t4_en", 20);
      repeat (T + 1) step();
      chk("t4_err_early", err_to, 0);
      step();
      chk("t4_err", err_to, 1);
      chk("t4_pending", pending, 0);
      chk("t4_phase", phase, -1);
      chk("t4_busy", busy, 0);
      clr = 1'b1; step(); clr = 1'b0;
      chk("t4_clr", err_to, 0);
      // saturation while unlocked, then drain
      locked = 1'b0; en_q.delete();
      repeat (200) begin ph_inc = 1'b1; step(); end
      ph_inc = 1'b0; step();
      chk("t5_pending", pending, PMAX);
      chk("t5_ovf", err_ovf, 1);
      chk("t5_no_pulse", en_q.size(), 0);
      locked = 1'b1; rsp_on = 1; lat = 1; dcnt = 0; en_q.delete();
      wait_idle("t5_idle", 2000);
      chk("t5_pulses", en_q.size(), PMAX);
      chk("t5_phase", phase, PMAX);
      // reset mid-WAIT, then a late ps_done
      rsp_on = 0; pll.ps_done = 1'b0;
      ph_inc = 1'b1; step(); ph_inc = 1'b0;
      wait_en("t6_en", 20);
      step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_pending", pending, 0);
      chk("t6_phase", phase, 0);
      chk("t6_ps_en", pll.ps_en, 0);
      chk("t6_incdec", pll.ps_incdec, 0);
      chk("t6_ovf", err_ovf, 0);
      pll.ps_done = 1'b1; step(); pll.ps_done = 1'b0; step();
      chk("t6_late_phase", phase, 0);
      chk("t6_late_busy", busy, 0);
      // randomized traffic with random PLL latency, spurious done, clr and reset
      rsp_on = 1; rnd_lat = 1; dcnt = 0;
      repeat (3000) begin
         ph_inc = $urandom_range(5, 0) == 0;
         ph_dec = $urandom_range(5, 0) == 0;
         locked = $urandom_range(15, 0) != 0;
         clr    = $urandom_range(63, 0) == 0;
         rst    = $urandom_range(399, 0) == 0;
         step();
      end
      ph_inc = 1'b0; ph_dec = 1'b0; clr = 1'b0; rst = 1'b0; locked = 1'b1;
      wait_idle("rnd_idle", 2000);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end
endmodule

// File: doc/pll_phase_step_ctrl_m.md
# pll_phase_step_ctrl_m

Sequencer between the delay-adjust loop and the dc PLL (MMCM) dynamic phase-shift port. Accumulates `ph_inc`/`ph_dec` step requests into a signed pending count and issues them one at a time as a `ps_en` pulse with `ps_incdec`. It waits for `ps_done`, with a timeout, and spaces consecutive steps by a guard gap. It also tracks the net applied phase for status readback.

## Interface
- `PEND_WIDTH`, 8: signed pending-step counter width; saturates at ±(2^(PEND_WIDTH-1)-1).
- `PHASE_WIDTH`, 16: signed applied-phase accumulator width; wraps modulo 2^PHASE_WIDTH.
- `TIMEOUT`, 1023: maximum WAIT cycles for `ps_done`; minimum 1.
- `GAP_CYCLES`, 4: idle cycles enforced after each completed step; 0 is allowed.

Ports:
- `clk`  in  1  PLL phase-shift clock (`psclk`), the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `ph_inc`  in  1  single-cycle request for +1 step.
- `ph_dec`  in  1  single-cycle request for −1 step.
- `locked`  in  1  PLL locked, already synchronised to `clk`.
- `clr`  in  1  clears `phase`, `err_timeout` and `err_ovf`.
- `ps_en`  out  1  PLL `psen`; one-cycle pulse.
- `ps_incdec`  out  1  PLL `psincdec`; 1 = increment.
- `ps_done`  in  1  PLL `psdone`.
- `busy`  out  1  high when state ≠ IDLE.
- `pending`  out  PEND_WIDTH  signed outstanding steps.
- `phase`  out  PHASE_WIDTH  signed net completed steps.
- `err_timeout`  out  1  sticky; a step timed out.
- `err_ovf`  out  1  sticky; a request was dropped at saturation.

## Operation
- Reset: state IDLE. All of the following are 0: `ps_en`, `ps_incdec`, `pending`, `phase`, `err_timeout`, `err_ovf`, `busy`, the gap counter and the timeout counter.
- Pending update each cycle: `pending_next = pending + ph_inc − ph_dec − consume`.
  - `consume` is ±1 in the committed direction when a step completes, otherwise 0.
  - Compute in PEND_WIDTH+1 bits, then clamp to ±(2^(PEND_WIDTH-1)-1).
  - If a clamp discards a request, set `err_ovf`.
  - `ph_inc` and `ph_dec` in the same cycle cancel.
- FSM states and transitions:
  - IDLE: if `pending` ≠ 0 and `locked` = 1, latch `dir = pending > 0` and go to ISSUE. Otherwise stay.
  - ISSUE, 1 cycle: `ps_en` = 1, `ps_incdec` = `dir`. Go to WAIT and load the timeout counter with TIMEOUT.
  - WAIT on `ps_done` = 1: complete the step. `phase` ±1 per `dir`, `pending` consumes 1 per `dir`. Go to GAP, or to IDLE if GAP_CYCLES = 0.
  - WAIT with no `ps_done`: decrement the timeout counter. When it reaches 0 without `ps_done`, set `err_timeout`, set `pending` to 0 (requests arriving that cycle are discarded), leave `phase` unchanged and go to IDLE.
  - GAP: count GAP_CYCLES, then go to IDLE.
- `dir` is committed at ISSUE. Requests arriving during WAIT can change the sign of `pending`, but the in-flight step still consumes in `dir`. The next IDLE decision uses the new sign.
- `ps_done` is ignored in IDLE, ISSUE and GAP (spurious or late completion); no counter changes.
- `locked` falling during WAIT/GAP does not abort; the step completes or times out normally. In IDLE, no step is issued while `locked` = 0, and `pending` is retained.
- `clr` zeroes `phase` and both error flags for one cycle.
  - It has priority over a same-cycle `phase` update or error set.
  - It does not touch `pending` or the FSM.
- `rst` asserted mid-step returns everything to reset values immediately. An outstanding PLL step is abandoned; the caller re-synchronises via `locked`.
- `ps_incdec` holds `dir` from ISSUE onward. It returns to 0 only on reset.

## Timing
- `ph_inc` at cycle 0 in IDLE with `locked` = 1:
  - `pending` = 1 at cycle 1.
  - ISSUE (`ps_en` = 1) at cycle 2.
  - WAIT from cycle 3.
- `ps_done` sampled at cycle n in WAIT: `phase` and `pending` update at n+1; GAP runs n+1 … n+GAP_CYCLES; IDLE at n+GAP_CYCLES+1.
- Back-to-back step period with immediate `ps_done` = 3 + GAP_CYCLES cycles.
- Timeout: WAIT entered at cycle w with no `ps_done` → `err_timeout` = 1 and IDLE at cycle w+TIMEOUT+1.
- All outputs are registered. `busy` is high from ISSUE through the last GAP cycle.

## Test plan
- After reset, 3× `ph_inc` spaced 1 cycle, `ps_done` 5 cycles after each `ps_en` → three `ps_en` pulses with `ps_incdec` = 1, each spaced ≥ 3+4 cycles; final `phase` = 3, `pending` = 0, `busy` falls.
- `ph_inc` and `ph_dec` in the same cycle while IDLE → `pending` stays 0, no `ps_en`.
- Step issued with `dir` = +1, then 2× `ph_dec` during WAIT, then `ps_done` → `phase` = 1, `pending` = −2; the next two steps have `ps_incdec` = 0 and end with `phase` = −1.
- Withhold `ps_done`, TIMEOUT = 16 → `err_timeout` = 1 exactly 17 cycles after WAIT entry; `pending` = 0, `phase` unchanged; `clr` → flag = 0.
- `locked` = 0 with 200× `ph_inc`, PEND_WIDTH = 8 → `pending` saturates at 127, `err_ovf` = 1, no `ps_en`. Then raise `locked` and answer every step → 127 pulses, `phase` = 127.
- `rst` pulsed in WAIT → all outputs 0 next cycle. A late `ps_done` afterwards causes no change.
